// File: rtl/sd_block_scrambler.sv
// sd_block_scrambler
// Read-modify-write client for the SD controller. For each block of a pass it
// captures the 512-bit read block and XORs it byte-serially with an 8-bit
// Galois LFSR keystream. The scrambled block goes back as write data, with a
// per-block checksum of the output bytes. After NUM_BLOCKS writes it reports
// done. A controller error aborts the pass and is never retried, because
// blocks that were already written carry the keystream.

module sd_block_scrambler #(
    parameter logic [31:0] NUM_BLOCKS = 32'd16,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    output logic         start_sequence,
    input  logic [511:0] read_data,
    input  logic         read_data_ready,
    input  logic         error,
    output logic         write_start,
    output logic         write_data_valid,
    output logic [511:0] write_data,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic [31:0]  blocks_done,
    output logic [7:0]   last_checksum
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_WAIT_RD  = 3'd2;
    localparam logic [2:0] S_XFORM    = 3'd3;
    localparam logic [2:0] S_ISSUE    = 3'd4;
    localparam logic [2:0] S_WAIT_ACK = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;
    localparam logic [2:0] S_FAIL     = 3'd7;

    // One step of the right-shifting Galois LFSR, feedback mask 8'hB8.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        logic [7:0] n;
        if (l[0]) begin
            n = (l >> 1) ^ 8'hB8;
        end else begin
            n = l >> 1;
        end
        return n;
    endfunction

    // Per-block seed. An all-zero LFSR would stay stuck, so zero maps to 8'h01.
    function automatic logic [7:0] block_seed(input logic [7:0] idx);
        logic [7:0] s;
        s = LFSR_SEED ^ idx;
        if (s == 8'h00) begin
            s = 8'h01;
        end else begin
            s = s;
        end
        return s;
    endfunction

    logic [2:0]   state_r;
    logic [2:0]   state_nxt_s;
    logic [511:0] sr_r;
    logic [7:0]   lfsr_r;
    logic [7:0]   acc_r;
    logic [5:0]   cnt_r;
    logic [511:0] write_data_r;
    logic [7:0]   last_checksum_r;
    logic [31:0]  blocks_done_r;
    logic         start_sequence_r;
    logic         write_start_r;
    logic         write_data_valid_r;
    logic         busy_r;
    logic         done_r;
    logic         fail_r;

    logic [7:0]   xf_out_s;
    logic [511:0] sr_shift_s;
    logic [7:0]   acc_nxt_s;
    logic         last_blk_s;
    logic         go_ok_s;
    logic         capture_s;
    logic         step_s;
    logic         final_s;
    logic         ack_s;

    assign xf_out_s   = sr_r[7:0] ^ lfsr_r;
    assign sr_shift_s = {xf_out_s, sr_r[511:8]};
    assign acc_nxt_s  = acc_r + xf_out_s;
    assign last_blk_s = ((blocks_done_r + 32'd1) == NUM_BLOCKS);

    // Next-state decode; error in any busy state wins over all progress.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_FAIL: begin
                if (go) begin
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_START: begin
                if (error) begin
                    state_nxt_s = S_FAIL;
                end else begin
                    state_nxt_s = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (error) begin
                    state_nxt_s = S_FAIL;
                end else if (read_data_ready) begin
                    state_nxt_s = S_XFORM;
                end else begin
                    state_nxt_s = S_WAIT_RD;
                end
            end
            S_XFORM: begin
                if (error) begin
                    state_nxt_s = S_FAIL;
                end else if (cnt_r == 6'd63) begin
                    state_nxt_s = S_ISSUE;
                end else begin
                    state_nxt_s = S_XFORM;
                end
            end
            S_ISSUE: begin
                if (error) begin
                    state_nxt_s = S_FAIL;
                end else begin
                    state_nxt_s = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (error) begin
                    state_nxt_s = S_FAIL;
                end else if (!read_data_ready) begin
                    if (last_blk_s) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_WAIT_RD;
                    end
                end else begin
                    state_nxt_s = S_WAIT_ACK;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Datapath events derived from the transition being taken this cycle.
    always_comb begin
        go_ok_s   = ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_FAIL)) && go;
        capture_s = (state_r == S_WAIT_RD) && (state_nxt_s == S_XFORM);
        step_s    = (state_r == S_XFORM) && (state_nxt_s != S_FAIL);
        final_s   = step_s && (cnt_r == 6'd63);
        ack_s     = (state_r == S_WAIT_ACK) &&
                    ((state_nxt_s == S_DONE) || (state_nxt_s == S_WAIT_RD));
    end

    // State register plus status/handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= S_IDLE;
            start_sequence_r   <= 1'b0;
            write_start_r      <= 1'b0;
            write_data_valid_r <= 1'b0;
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
            fail_r             <= 1'b0;
        end else begin
            state_r            <= state_nxt_s;
            start_sequence_r   <= (state_nxt_s == S_START);
            write_start_r      <= (state_nxt_s == S_ISSUE) || (state_nxt_s == S_WAIT_ACK);
            write_data_valid_r <= (state_nxt_s == S_ISSUE) || (state_nxt_s == S_WAIT_ACK);
            busy_r             <= (state_nxt_s == S_START) || (state_nxt_s == S_WAIT_RD) ||
                                  (state_nxt_s == S_XFORM) || (state_nxt_s == S_ISSUE) ||
                                  (state_nxt_s == S_WAIT_ACK);
            done_r             <= (state_nxt_s == S_DONE);
            fail_r             <= (state_nxt_s == S_FAIL);
        end
    end

    // Block capture and the byte-serial XOR / checksum engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r   <= 512'd0;
            lfsr_r <= 8'h00;
            acc_r  <= 8'h00;
            cnt_r  <= 6'd0;
        end else if (capture_s) begin
            sr_r   <= read_data;
            lfsr_r <= block_seed(blocks_done_r[7:0]);
            acc_r  <= 8'h00;
            cnt_r  <= 6'd0;
        end else if (step_s) begin
            sr_r   <= sr_shift_s;
            lfsr_r <= lfsr_step(lfsr_r);
            acc_r  <= acc_nxt_s;
            cnt_r  <= cnt_r + 6'd1;
        end else begin
            sr_r   <= sr_r;
            lfsr_r <= lfsr_r;
            acc_r  <= acc_r;
            cnt_r  <= cnt_r;
        end
    end

    // Write data is loaded once per block and frozen through the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_data_r <= 512'd0;
        end else if (final_s) begin
            write_data_r <= sr_shift_s;
        end else begin
            write_data_r <= write_data_r;
        end
    end

    // Pass progress counter and per-block checksum, both cleared by an accepted go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocks_done_r   <= 32'd0;
            last_checksum_r <= 8'h00;
        end else if (go_ok_s) begin
            blocks_done_r   <= 32'd0;
            last_checksum_r <= 8'h00;
        end else if (final_s) begin
            blocks_done_r   <= blocks_done_r;
            last_checksum_r <= acc_nxt_s;
        end else if (ack_s) begin
            blocks_done_r   <= blocks_done_r + 32'd1;
            last_checksum_r <= last_checksum_r;
        end else begin
            blocks_done_r   <= blocks_done_r;
            last_checksum_r <= last_checksum_r;
        end
    end

    assign start_sequence   = start_sequence_r;
    assign write_start      = write_start_r;
    assign write_data_valid = write_data_valid_r;
    assign write_data       = write_data_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign fail             = fail_r;
    assign blocks_done      = blocks_done_r;
    assign last_checksum    = last_checksum_r;

endmodule

// File: tb/tb_sd_block_scrambler.sv
// Testbench for sd_block_scrambler. Three instances with different pass
// lengths and seeds, driven by a small controller emulation and checked
// against a byte-level keystream model.

module tb_sd_block_scrambler;

    logic               clk;
    logic [2:0]         rst_n_v;
    logic [2:0]         go_v;
    logic [2:0][511:0]  rd_v;
    logic [2:0]         rdy_v;
    logic [2:0]         err_v;
    logic [2:0]         ss_v;
    logic [2:0]         ws_v;
    logic [2:0]         wv_v;
    logic [2:0][511:0]  wd_v;
    logic [2:0]         busy_v;
    logic [2:0]         done_v;
    logic [2:0]         fail_v;
    logic [2:0][31:0]   bd_v;
    logic [2:0][7:0]    cs_v;

    int n_checks = 0;
    int n_pass   = 0;
    logic [511:0] cap [8];

    // Instance 0: 1 block, seed A5. Instance 1: 3 blocks, seed A5. Instance 2: 6 blocks, seed 05.
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            sd_block_scrambler #(
                .NUM_BLOCKS((g == 0) ? 32'd1 : ((g == 1) ? 32'd3 : 32'd6)),
                .LFSR_SEED ((g == 2) ? 8'h05 : 8'hA5)
            ) u_dut (
                .clk             (clk),
                .rst_n           (rst_n_v[g]),
                .go              (go_v[g]),
                .start_sequence  (ss_v[g]),
                .read_data       (rd_v[g]),
                .read_data_ready (rdy_v[g]),
                .error           (err_v[g]),
                .write_start     (ws_v[g]),
                .write_data_valid(wv_v[g]),
                .write_data      (wd_v[g]),
                .busy            (busy_v[g]),
                .done            (done_v[g]),
                .fail            (fail_v[g]),
                .blocks_done     (bd_v[g]),
                .last_checksum   (cs_v[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] seed_of(input int i, input int idx);
        logic [7:0] base;
        logic [7:0] s;
        logic [31:0] iv;
        iv = idx;
        base = (i == 2) ? 8'h05 : 8'hA5;
        s = base ^ iv[7:0];
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [511:0] model_out(input logic [511:0] din, input logic [7:0] seed);
        logic [511:0] res;
        logic [7:0] k;
        k = seed;
        for (int b = 0; b < 64; b++) begin
            res[8*b +: 8] = din[8*b +: 8] ^ k;
            k = k[0] ? ((k >> 1) ^ 8'hB8) : (k >> 1);
        end
        return res;
    endfunction

    function automatic logic [7:0] model_sum(input logic [511:0] d);
        int s;
        s = 0;
        for (int b = 0; b < 64; b++) s = s + int'(d[8*b +: 8]);
        return 8'(s % 256);
    endfunction

    function automatic logic [511:0] gen_block(input int mode);
        logic [511:0] d;
        d = 512'd0;
        for (int b = 0; b < 64; b++) begin
            if (mode == 1) d[8*b +: 8] = 8'(b);
        end
        if (mode == 2) begin
            for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- controller emulation ----------------
    task automatic start_pass(input int i, input bit with_err);
        int pulses;
        pulses = 0;
        @(negedge clk);
        go_v[i] = 1'b1;
        err_v[i] = with_err;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            go_v[i] = 1'b0;
            err_v[i] = 1'b0;
            if (ss_v[i]) pulses++;
        end
        check("start_pulse_count", pulses, 1);
        check("go_clears_status", {done_v[i], fail_v[i], bd_v[i], cs_v[i]}, 0);
        check("busy_after_go", busy_v[i], 1);
    endtask

    task automatic do_block(input int i, input int idx, input logic [511:0] din,
                            input int hold, input bit noisy, input bit go_busy);
        logic [511:0] exp_wd;
        logic [511:0] wd0;
        logic [7:0]   seed;
        int lat;
        int ss_cnt;
        bit stable;
        seed = seed_of(i, idx);
        exp_wd = model_out(din, seed);
        rd_v[i] = din;
        rdy_v[i] = 1'b1;
        lat = 0;
        ss_cnt = 0;
        while (!ws_v[i] && lat < 200) begin
            @(negedge clk);
            lat++;
            if (ss_v[i]) ss_cnt++;
            if (noisy && lat < 60) begin
                rdy_v[i] = 1'($urandom_range(0, 1));
                rd_v[i] = gen_block(2);
            end else begin
                rdy_v[i] = 1'b1;
            end
            go_v[i] = (go_busy && lat == 30) ? 1'b1 : 1'b0;
        end
        check("write_latency", lat, 65);
        check("no_start_while_busy", ss_cnt, 0);
        check("write_data", wd_v[i], exp_wd);
        check("descramble", model_out(wd_v[i], seed), din);
        check("checksum", cs_v[i], model_sum(exp_wd));
        check("write_valid", wv_v[i], 1);
        wd0 = wd_v[i];
        stable = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (!ws_v[i] || !wv_v[i] || wd_v[i] !== wd0 || bd_v[i] !== 32'(idx)) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", stable, 1);
        check("blocks_before_ack", bd_v[i], idx);
        rdy_v[i] = 1'b0;
        lat = 0;
        while (ws_v[i] && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("ack_drops_write_start", {ws_v[i], wv_v[i]}, 0);
        check("blocks_after_ack", bd_v[i], idx + 1);
        cap[idx] = wd0;
    endtask

    task automatic run_pass(input int i, input int nblk, input int mode,
                            input int hold_blk, input int gob_blk, input bit with_err);
        start_pass(i, with_err);
        for (int b = 0; b < nblk; b++) begin
            do_block(i, b, gen_block(mode), (b == hold_blk) ? 20 : 0, mode == 2, b == gob_blk);
        end
        check("pass_done", {done_v[i], fail_v[i], busy_v[i]}, 3'b100);
        check("pass_blocks", bd_v[i], nblk);
    endtask

    typedef struct {
        int          inst;
        int          nblk;
        int          mode;
        int          blk;
        logic [31:0] exp4;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int ws_seen;
        // First four output bytes (byte0 in the low 8 bits) for hand-derived cases.
        tbl[0] = '{0, 1, 0, 0, 32'h8275EAA5};  // zero block, seed A5
        tbl[1] = '{1, 3, 0, 1, 32'hAC2952A4};  // zero block, seed A4
        tbl[2] = '{1, 3, 1, 0, 32'h8177EBA5};  // byte k = k, seed A5
        tbl[3] = '{2, 6, 0, 5, 32'h2E5CB801};  // seed 05^05 = 0 -> 01
        tbl[4] = '{2, 6, 0, 0, 32'h965DBA05};  // seed 05

        rst_n_v = 3'b000;
        go_v = 3'b000;
        rdy_v = 3'b000;
        err_v = 3'b000;
        rd_v = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_ctl", {ss_v[i], ws_v[i], wv_v[i], busy_v[i], done_v[i], fail_v[i], bd_v[i], cs_v[i]}, 0);
            check("reset_wdata", wd_v[i], 0);
        end
        @(negedge clk);
        rst_n_v = 3'b111;
        @(negedge clk);

        // Table-driven keystream vectors.
        for (int t = 0; t < 5; t++) begin
            run_pass(tbl[t].inst, tbl[t].nblk, tbl[t].mode, -1, -1, 1'b0);
            check("table_bytes", cap[tbl[t].blk][31:0], tbl[t].exp4);
        end

        // Error while done is ignored; done stays sticky.
        @(negedge clk);
        err_v[0] = 1'b1;
        @(negedge clk);
        err_v[0] = 1'b0;
        @(negedge clk);
        check("error_in_done_ignored", {done_v[0], fail_v[0], busy_v[0]}, 3'b100);

        // Byte k = k over three blocks, write acceptance held off 20 cycles on block 1.
        run_pass(1, 3, 1, 1, -1, 1'b0);

        // Error during XFORM of block 2: abort with two blocks written, no write issued.
        start_pass(2, 1'b0);
        do_block(2, 0, gen_block(2), 0, 1'b0, 1'b0);
        do_block(2, 1, gen_block(2), 0, 1'b0, 1'b0);
        rd_v[2] = gen_block(2);
        rdy_v[2] = 1'b1;
        repeat (10) @(negedge clk);
        err_v[2] = 1'b1;
        @(negedge clk);
        err_v[2] = 1'b0;
        check("error_to_fail", {fail_v[2], done_v[2], busy_v[2], ws_v[2]}, 4'b1000);
        check("error_blocks_done", bd_v[2], 2);
        ws_seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ws_v[2]) ws_seen++;
        end
        check("no_write_after_error", ws_seen, 0);
        rdy_v[2] = 1'b0;
        err_v[2] = 1'b1;
        @(negedge clk);
        err_v[2] = 1'b0;
        @(negedge clk);
        check("fail_sticky", {fail_v[2], busy_v[2]}, 2'b10);
        // Restart with go and error together (go wins), random data, go pulsed mid-pass.
        run_pass(2, 6, 2, -1, 3, 1'b1);

        // Asynchronous reset in the middle of XFORM.
        start_pass(1, 1'b0);
        rd_v[1] = gen_block(2);
        rdy_v[1] = 1'b1;
        repeat (20) @(negedge clk);
        rst_n_v[1] = 1'b0;
        #1;
        check("midpass_reset_ctl", {ss_v[1], ws_v[1], wv_v[1], busy_v[1], done_v[1], fail_v[1], bd_v[1], cs_v[1]}, 0);
        check("midpass_reset_wdata", wd_v[1], 0);
        rdy_v[1] = 1'b0;
        @(negedge clk);
        rst_n_v[1] = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy_v[1], ws_v[1]}, 0);
        run_pass(1, 3, 2, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
